// File: rtl/ervp_cache_access_arbiter.sv
// ervp_cache_access_arbiter
// Two-requester arbiter in front of a single-beat cache port. Requests are
// granted round-robin, read responses come back in order and are steered to
// the requester that issued them via a small ID FIFO (ordq).
module ervp_cache_access_arbiter #(
    parameter int BW_ADDR         = 32,
    parameter int BW_ACCESS       = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                   clk,
    input  logic                   rstnn,
    input  logic                   clear,
    output logic                   busy,
    output logic                   resp_error,

    input  logic                   r0_cqvalid,
    output logic                   r0_cqready,
    input  logic [BW_ADDR-1:0]     r0_cqaddr,
    input  logic                   r0_cqwrite,
    input  logic [BW_ACCESS/8-1:0] r0_cqwstrb,
    input  logic [BW_ACCESS-1:0]   r0_cqwdata,
    output logic                   r0_cyvalid,
    output logic [BW_ACCESS-1:0]   r0_cyrdata,

    input  logic                   r1_cqvalid,
    output logic                   r1_cqready,
    input  logic [BW_ADDR-1:0]     r1_cqaddr,
    input  logic                   r1_cqwrite,
    input  logic [BW_ACCESS/8-1:0] r1_cqwstrb,
    input  logic [BW_ACCESS-1:0]   r1_cqwdata,
    output logic                   r1_cyvalid,
    output logic [BW_ACCESS-1:0]   r1_cyrdata,

    output logic                   m_cqvalid,
    input  logic                   m_cqready,
    output logic [BW_ADDR-1:0]     m_cqaddr,
    output logic                   m_cqwrite,
    output logic [BW_ACCESS/8-1:0] m_cqwstrb,
    output logic [BW_ACCESS-1:0]   m_cqwdata,
    input  logic                   m_cyvalid,
    input  logic [BW_ACCESS-1:0]   m_cyrdata
);

    localparam int BW_PTR = $clog2(MAX_OUTSTANDING);
    localparam int BW_CNT = BW_PTR + 1;
    localparam logic [BW_CNT-1:0] FULL_CNT = BW_CNT'(MAX_OUTSTANDING);

    // ordering FIFO state and arbitration state
    logic [MAX_OUTSTANDING-1:0] r_ordq;
    logic [BW_PTR-1:0]          r_wptr;
    logic [BW_PTR-1:0]          r_rptr;
    logic [BW_CNT-1:0]          r_count;
    logic                       r_prio;
    logic                       r_resp_error;

    logic w_empty;
    logic w_full;
    logic w_elig0;
    logic w_elig1;
    logic w_gnt0;
    logic w_gnt1;
    logic w_gid;
    logic w_hs;
    logic w_push;
    logic w_pop;
    logic w_orphan;
    logic w_head;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == FULL_CNT);

    // reads need a free ordq slot; writes never occupy one
    assign w_elig0  = r0_cqvalid & (r0_cqwrite | ~w_full);
    assign w_elig1  = r1_cqvalid & (r1_cqwrite | ~w_full);

    // r_prio names the requester that wins a tie
    assign w_gnt0   = rstnn & w_elig0 & (~w_elig1 | ~r_prio);
    assign w_gnt1   = rstnn & w_elig1 & (~w_elig0 |  r_prio);
    assign w_gid    = w_gnt1;

    assign m_cqvalid  = w_gnt0 | w_gnt1;
    assign r0_cqready = m_cqready & w_gnt0;
    assign r1_cqready = m_cqready & w_gnt1;

    assign w_hs     = m_cqvalid & m_cqready;
    // pushes in a clear cycle are dropped so the flush leaves ordq empty
    assign w_push   = w_hs & ~m_cqwrite & ~clear;
    assign w_pop    = m_cyvalid & ~w_empty;
    assign w_orphan = m_cyvalid &  w_empty;
    assign w_head   = r_ordq[r_rptr];

    assign r0_cyvalid = w_pop & ~w_head;
    assign r1_cyvalid = w_pop &  w_head;
    assign r0_cyrdata = m_cyrdata;
    assign r1_cyrdata = m_cyrdata;

    assign busy       = ~w_empty;
    assign resp_error = r_resp_error;

    // forward the granted requester's payload to the cache
    always_comb begin
        m_cqaddr  = r0_cqaddr;
        m_cqwrite = r0_cqwrite;
        m_cqwstrb = r0_cqwstrb;
        m_cqwdata = r0_cqwdata;
        if (w_gnt1) begin
            m_cqaddr  = r1_cqaddr;
            m_cqwrite = r1_cqwrite;
            m_cqwstrb = r1_cqwstrb;
            m_cqwdata = r1_cqwdata;
        end
    end

    // ordq storage: record the requester ID of each accepted read
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_ordq[r_wptr] <= w_gid;
        end
    end

    // ordq pointers and occupancy; pointers wrap naturally (power-of-2 depth)
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + BW_PTR'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + BW_PTR'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + BW_CNT'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - BW_CNT'(1);
            end
        end
    end

    // round-robin pointer: after a handshake the loser gets the next tie
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            r_prio <= 1'b0;
        end else if (clear) begin
            r_prio <= 1'b0;
        end else if (w_hs) begin
            r_prio <= ~w_gid;
        end
    end

    // sticky flag for responses arriving with nothing outstanding
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            r_resp_error <= 1'b0;
        end else if (clear) begin
            r_resp_error <= 1'b0;
        end else if (w_orphan) begin
            r_resp_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ervp_cache_access_arbiter.sv
// Scoreboard bench for ervp_cache_access_arbiter: a cache model answers reads
// in order, expected read data is queued per requester at each accepted read
// and compared when that requester sees its response.
module tb_ervp_cache_access_arbiter;

    logic        clk = 1'b0;
    logic        rstnn;
    logic        clear;
    logic        busy, resp_error;
    logic        r0_cqvalid, r0_cqready, r0_cqwrite, r0_cyvalid;
    logic [31:0] r0_cqaddr, r0_cqwdata, r0_cyrdata;
    logic [3:0]  r0_cqwstrb;
    logic        r1_cqvalid, r1_cqready, r1_cqwrite, r1_cyvalid;
    logic [31:0] r1_cqaddr, r1_cqwdata, r1_cyrdata;
    logic [3:0]  r1_cqwstrb;
    logic        m_cqvalid, m_cqready, m_cqwrite, m_cyvalid;
    logic [31:0] m_cqaddr, m_cqwdata, m_cyrdata;
    logic [3:0]  m_cqwstrb;

    always #5 clk = ~clk;

    ervp_cache_access_arbiter #(
        .BW_ADDR(32),
        .BW_ACCESS(32),
        .MAX_OUTSTANDING(4)
    ) dut (
        .clk(clk), .rstnn(rstnn), .clear(clear), .busy(busy), .resp_error(resp_error),
        .r0_cqvalid(r0_cqvalid), .r0_cqready(r0_cqready), .r0_cqaddr(r0_cqaddr),
        .r0_cqwrite(r0_cqwrite), .r0_cqwstrb(r0_cqwstrb), .r0_cqwdata(r0_cqwdata),
        .r0_cyvalid(r0_cyvalid), .r0_cyrdata(r0_cyrdata),
        .r1_cqvalid(r1_cqvalid), .r1_cqready(r1_cqready), .r1_cqaddr(r1_cqaddr),
        .r1_cqwrite(r1_cqwrite), .r1_cqwstrb(r1_cqwstrb), .r1_cqwdata(r1_cqwdata),
        .r1_cyvalid(r1_cyvalid), .r1_cyrdata(r1_cyrdata),
        .m_cqvalid(m_cqvalid), .m_cqready(m_cqready), .m_cqaddr(m_cqaddr),
        .m_cqwrite(m_cqwrite), .m_cqwstrb(m_cqwstrb), .m_cqwdata(m_cqwdata),
        .m_cyvalid(m_cyvalid), .m_cyrdata(m_cyrdata)
    );

    typedef struct {
        int          due;
        logic [31:0] data;
    } pend_t;

    int          n_total = 0;
    int          n_bad   = 0;
    int          cyc     = 0;
    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];
    pend_t       pq[$];
    bit          auto_rsp, fire_rsp, orphan_rsp;
    bit          hs0, hs1;
    int          last_gid;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    // one clock cycle: drive cache side, sample outputs mid-cycle, step edge
    task automatic tick();
        m_cyvalid = 1'b0;
        m_cyrdata = '0;
        last_gid  = 2;
        if (orphan_rsp) begin
            m_cyvalid = 1'b1;
            m_cyrdata = 32'hDEAD_BEEF;
        end else if (pq.size() > 0 && ((auto_rsp && pq[0].due <= cyc) || fire_rsp)) begin
            m_cyvalid = 1'b1;
            m_cyrdata = pq[0].data;
            void'(pq.pop_front());
        end
        #2;
        if (r0_cyvalid) begin
            if (exp_q0.size() == 0) chk("r0_unexpected_rsp", 1, 0);
            else                    chk("r0_rdata", r0_cyrdata, exp_q0.pop_front());
        end
        if (r1_cyvalid) begin
            if (exp_q1.size() == 0) chk("r1_unexpected_rsp", 1, 0);
            else                    chk("r1_rdata", r1_cyrdata, exp_q1.pop_front());
        end
        hs0 = r0_cqvalid & r0_cqready;
        hs1 = r1_cqvalid & r1_cqready;
        if (hs0 | hs1) chk("single_grant", {hs0, hs1} == 2'b11, 0);
        if (hs0) begin
            last_gid = 0;
            if (!r0_cqwrite) begin
                pq.push_back('{cyc + 2, rd_of(r0_cqaddr)});
                if (!clear) exp_q0.push_back(rd_of(r0_cqaddr));
            end
        end
        if (hs1) begin
            last_gid = 1;
            if (!r1_cqwrite) begin
                pq.push_back('{cyc + 2, rd_of(r1_cqaddr)});
                if (!clear) exp_q1.push_back(rd_of(r1_cqaddr));
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        clear      = 1'b0;
        r0_cqvalid = 1'b0; r0_cqaddr = '0; r0_cqwrite = 1'b0; r0_cqwstrb = '0; r0_cqwdata = '0;
        r1_cqvalid = 1'b0; r1_cqaddr = '0; r1_cqwrite = 1'b0; r1_cqwstrb = '0; r1_cqwdata = '0;
        m_cqready  = 1'b0; m_cyvalid = 1'b0; m_cyrdata = '0;
        auto_rsp = 0; fire_rsp = 0; orphan_rsp = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rstnn = 1'b0;
        repeat (2) @(negedge clk);
        rstnn = 1'b1;
        @(negedge clk);
        exp_q0.delete();
        exp_q1.delete();
        pq.delete();
    endtask

    initial begin
        int n0, n1, exp_g;
        do_reset();
        chk("rst_busy", busy, 0);
        chk("rst_resp_error", resp_error, 0);

        // ready held low with both requesting: nothing moves, prio stays 0
        r0_cqvalid = 1; r0_cqaddr = 32'h0000_2000;
        r1_cqvalid = 1; r1_cqaddr = 32'h0000_3000;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_mvalid", m_cqvalid, 1);
            chk("stall_no_hs", hs0 | hs1, 0);
        end
        m_cqready = 1;
        tick();
        chk("stall_release_gid", last_gid, 0);
        idle_inputs();
        auto_rsp = 1;
        repeat (4) tick();
        chk("stall_drain_busy", busy, 0);

        // streaming reads from both sides, cache answers two cycles later
        do_reset();
        auto_rsp = 1; m_cqready = 1;
        r0_cqvalid = 1; r1_cqvalid = 1;
        n0 = 0; n1 = 0; exp_g = 0;
        for (int i = 0; i < 8; i++) begin
            r0_cqaddr = 32'h0000_1000 + 32'(4 * n0);
            r1_cqaddr = 32'h0008_0000 + 32'(4 * n1);
            tick();
            chk("alt_gid", last_gid, exp_g);
            exp_g ^= 1;
            if (hs0) n0++;
            if (hs1) n1++;
        end
        r0_cqvalid = 0; r1_cqvalid = 0;
        repeat (4) tick();
        chk("alt_drain_busy", busy, 0);
        chk("alt_q0_empty", exp_q0.size(), 0);
        chk("alt_q1_empty", exp_q1.size(), 0);

        // fill ordq, write bypasses full, push blocked while popping
        do_reset();
        m_cqready = 1;
        r0_cqvalid = 1;
        for (int i = 0; i < 4; i++) begin
            r0_cqaddr = 32'h0000_4000 + 32'(16 * i);
            tick();
            chk("fill_hs", hs0, 1);
        end
        chk("full_busy", busy, 1);
        r0_cqaddr = 32'h0000_4100;
        r1_cqvalid = 1; r1_cqwrite = 1; r1_cqaddr = 32'h0000_9000;
        r1_cqwdata = 32'h1234_5678; r1_cqwstrb = 4'hF;
        tick();
        chk("full_rd_blocked", hs0, 0);
        chk("full_wr_accepted", hs1, 1);
        r1_cqvalid = 0; r1_cqwrite = 0;
        fire_rsp = 1;
        tick();
        chk("full_pop_push_blocked", hs0, 0);
        fire_rsp = 0;
        tick();
        chk("after_pop_rd_accepted", hs0, 1);
        r0_cqaddr = 32'h0000_4200;
        tick();
        chk("refull_rd_blocked", hs0, 0);
        r0_cqvalid = 0;
        fire_rsp = 1;
        repeat (5) tick();
        fire_rsp = 0;
        chk("full_drain_busy", busy, 0);
        chk("full_q0_empty", exp_q0.size(), 0);

        // orphan response, sticky error, then clear flushes everything
        do_reset();
        m_cqready = 1;
        orphan_rsp = 1;
        tick();
        orphan_rsp = 0;
        chk("orphan_r0_cyvalid", r0_cyvalid, 0);
        chk("orphan_r1_cyvalid", r1_cyvalid, 0);
        chk("orphan_resp_error", resp_error, 1);
        r0_cqvalid = 1; r0_cqaddr = 32'h0000_5000;
        tick();
        r0_cqvalid = 0;
        chk("inflight_busy", busy, 1);
        chk("sticky_resp_error", resp_error, 1);
        clear = 1;
        tick();
        clear = 0;
        exp_q0.delete();
        pq.delete();
        chk("clear_resp_error", resp_error, 0);
        chk("clear_busy", busy, 0);
        r0_cqvalid = 1; r0_cqaddr = 32'h0000_5100;
        r1_cqvalid = 1; r1_cqaddr = 32'h0000_6100;
        tick();
        chk("clear_prio_gid", last_gid, 0);
        r0_cqvalid = 0; r1_cqvalid = 0;
        fire_rsp = 1;
        tick();
        fire_rsp = 0;
        chk("clear_drain_busy", busy, 0);

        // reset with reads in flight abandons them
        do_reset();
        m_cqready = 1;
        r0_cqvalid = 1; r0_cqaddr = 32'h0000_7000;
        tick();
        r0_cqaddr = 32'h0000_7004;
        tick();
        chk("pre_rst_busy", busy, 1);
        r1_cqvalid = 1; r1_cqaddr = 32'h0000_8000;
        rstnn = 0;
        m_cyvalid = 1; m_cyrdata = 32'hCAFE_0000;
        #1;
        chk("in_rst_busy", busy, 0);
        chk("in_rst_mvalid", m_cqvalid, 0);
        chk("in_rst_r0_ready", r0_cqready, 0);
        chk("in_rst_r1_ready", r1_cqready, 0);
        chk("in_rst_r0_cyvalid", r0_cyvalid, 0);
        chk("in_rst_r1_cyvalid", r1_cyvalid, 0);
        r0_cqvalid = 0; r1_cqvalid = 0; m_cyvalid = 0;
        @(negedge clk);
        rstnn = 1;
        @(negedge clk);
        exp_q0.delete();
        exp_q1.delete();
        fire_rsp = 1;
        repeat (2) tick();
        fire_rsp = 0;
        chk("post_rst_resp_error", resp_error, 1);
        chk("post_rst_busy", busy, 0);
        r0_cqvalid = 1; r0_cqaddr = 32'h0000_7100;
        r1_cqvalid = 1; r1_cqaddr = 32'h0000_8100;
        tick();
        chk("post_rst_prio_gid", last_gid, 0);
        r0_cqvalid = 0; r1_cqvalid = 0;
        fire_rsp = 1;
        tick();
        fire_rsp = 0;
        chk("end_busy", busy, 0);
        chk("end_q0_empty", exp_q0.size(), 0);
        chk("end_q1_empty", exp_q1.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/ervp_cache_access_arbiter.md
ERVP_CACHE_ACCESS_ARBITER -- requirements
Module: ervp_cache_access_arbiter

Interface
REQ-001 SHALL have parameter BW_ADDR, default 32, address width.
REQ-002 SHALL have parameter BW_ACCESS, default 32, access data width (multiple of 8).
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 4, maximum in-flight reads (power of 2, >=2).
REQ-004 SHALL use one clock; reset is asynchronous and active-low. Ports: clk input 1 clock; rstnn input 1 asynchronous active-low reset.
REQ-005 SHALL have ports: clear input 1 synchronous flush; busy output 1 reads in flight; resp_error output 1 sticky orphan-response flag.
REQ-006 SHALL have, for each requester N in {0,1}: rN_cqvalid input 1; rN_cqready output 1; rN_cqaddr input BW_ADDR; rN_cqwrite input 1; rN_cqwstrb input BW_ACCESS/8; rN_cqwdata input BW_ACCESS; rN_cyvalid output 1; rN_cyrdata output BW_ACCESS.
REQ-007 SHALL have cache-side ports: m_cqvalid output 1; m_cqready input 1; m_cqaddr output BW_ADDR; m_cqwrite output 1; m_cqwstrb output BW_ACCESS/8; m_cqwdata output BW_ACCESS; m_cyvalid input 1; m_cyrdata input BW_ACCESS.

Function
REQ-008 SHALL treat each request as single-beat; handshake on valid&ready in the same cycle; writes produce no response; reads produce exactly one m_cyvalid pulse, returned in request order.
REQ-009 SHALL define eligible(N) = rN_cqvalid & (rN_cqwrite | ~ordq_full).
REQ-010 SHALL grant combinationally in the request cycle: only one eligible -> that one; both eligible -> requester indicated by priority pointer prio.
REQ-011 SHALL drive m_cqvalid = eligible(0)|eligible(1); m_cq* payload = granted requester's fields; with no grant, payload is don't-care.
REQ-012 SHALL drive rN_cqready = m_cqready & grant(N); non-granted requester ready = 0.
REQ-013 SHALL update prio to the non-winning requester on the clock edge after an accepted handshake (m_cqvalid&m_cqready); no handshake -> prio unchanged.
REQ-014 SHALL keep an ordering FIFO (ordq) of 1-bit requester IDs, depth MAX_OUTSTANDING, count width log2(MAX_OUTSTANDING)+1.
REQ-015 SHALL push the granted ID on every accepted read handshake; SHALL pop on m_cyvalid when non-empty; simultaneous push/pop keeps count unchanged and preserves order.
REQ-016 SHALL assert ordq_full when count==MAX_OUTSTANDING, blocking new reads in that cycle even if a pop occurs simultaneously; writes remain eligible.
REQ-017 SHALL route responses with zero latency: rN_cyvalid = m_cyvalid & ~ordq_empty & (ordq head==N); rN_cyrdata = m_cyrdata for both requesters.
REQ-018 SHALL, on m_cyvalid with ordq empty, drop the response (no rN_cyvalid), not change count, and set resp_error, which stays 1 until reset or clear.
REQ-019 SHALL drive busy = ~ordq_empty.
REQ-020 SHALL, on clear=1, at the next edge empty ordq, set prio=0, and clear resp_error; requests in the clear cycle are still arbitrated, but their ordq pushes are discarded; responses in that cycle are routed per pre-clear state.
REQ-021 SHALL wrap ordq read/write pointers modulo MAX_OUTSTANDING.

Reset
REQ-022 SHALL, while rstnn=0, asynchronously force: ordq empty (count=0, pointers=0), prio=0, resp_error=0.
REQ-023 SHALL, during reset, output busy=0, rN_cyvalid=0, rN_cqready=0, m_cqvalid=0 regardless of inputs.
REQ-024 SHALL, on reset assertion mid-transaction, abandon all in-flight read IDs; later responses set resp_error per REQ-018.

Verification
REQ-025 SHALL cover: both requesters issue reads each cycle, m_cqready=1, cache replies 2 cycles later -> grants alternate 0,1,0,1 and rN_cyvalid matches each requester's own address order.
REQ-026 SHALL cover: MAX_OUTSTANDING=4, 4 reads accepted, no response -> count=4, busy=1, 5th read ready=0, concurrent write from r1 accepted; one m_cyvalid -> read accepted next cycle.
REQ-027 SHALL cover: m_cqready=0 for 3 cycles with both valid -> no handshake, prio unchanged, r0 granted when ready rises (prio=0 after reset).
REQ-028 SHALL cover: full queue with push attempt and pop same cycle -> push blocked, count 4->3.
REQ-029 SHALL cover: m_cyvalid with empty queue -> no rN_cyvalid, resp_error=1; then clear=1 -> resp_error=0, busy=0.
REQ-030 SHALL cover: rstnn=0 asserted with 2 reads in flight -> busy=0 immediately, prio=0; response after release -> resp_error=1.
